// File: rtl/change_dispenser_if.sv
// Refund request and coin-hopper handshakes for the change dispenser.
// slave = dispenser side, master = vending controller / hopper side.
interface change_dispenser_if;
  logic       refund_valid;
  logic [2:0] refund_amt;
  logic       refund_ready;
  logic [4:0] coin_out;
  logic       coin_valid;
  logic       coin_ack;

  modport master (
    output refund_valid, refund_amt, coin_ack,
    input  refund_ready, coin_out, coin_valid
  );

  modport slave (
    input  refund_valid, refund_amt, coin_ack,
    output refund_ready, coin_out, coin_valid
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays a quarter-unit refund out of a loadable coin
// inventory, one coin per valid/ack handshake, and flags a shortfall if stuck.
module change_dispenser #(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus,
  input  logic               load_en,
  input  logic [COUNT_W-1:0] load_q,
  input  logic [COUNT_W-1:0] load_f,
  input  logic [COUNT_W-1:0] load_d,
  output logic [COUNT_W-1:0] cnt_q,
  output logic [COUNT_W-1:0] cnt_f,
  output logic [COUNT_W-1:0] cnt_d,
  output logic               busy,
  output logic [2:0]         remaining,
  output logic               done,
  output logic               short
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_SHORT} state_t;

  localparam logic [4:0] COIN_NONE = 5'b00000;
  localparam logic [4:0] COIN_QTR  = 5'b00001;
  localparam logic [4:0] COIN_FIF  = 5'b00010;
  localparam logic [4:0] COIN_DOL  = 5'b01000;
  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t             state_q, state_d;
  logic [2:0]         rem_q, rem_d;
  logic [COUNT_W-1:0] nq_q, nq_d, nf_q, nf_d, nd_q, nd_d;
  logic [4:0]         coin_q, coin_d;
  logic               cvld_q, cvld_d;
  logic               done_q, done_d;
  logic               short_q, short_d;
  logic [2:0]         coin_val;

  // Value in quarters of the coin currently presented to the hopper.
  always_comb begin
    case (coin_q)
      COIN_DOL: coin_val = 3'd4;
      COIN_FIF: coin_val = 3'd2;
      COIN_QTR: coin_val = 3'd1;
      default:  coin_val = 3'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    nq_d    = nq_q;
    nf_d    = nf_q;
    nd_d    = nd_q;
    coin_d  = coin_q;
    cvld_d  = cvld_q;
    done_d  = 1'b0;
    short_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          nq_d = load_q;
          nf_d = load_f;
          nd_d = load_d;
        end
        if (bus.refund_valid) begin
          rem_d   = bus.refund_amt;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 3'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (rem_q >= 3'd4 && nd_q != '0) begin
          coin_d = COIN_DOL; cvld_d = 1'b1; state_d = S_ISSUE;
        end else if (rem_q >= 3'd2 && nf_q != '0) begin
          coin_d = COIN_FIF; cvld_d = 1'b1; state_d = S_ISSUE;
        end else if (nq_q != '0) begin
          coin_d = COIN_QTR; cvld_d = 1'b1; state_d = S_ISSUE;
        end else begin
          state_d = S_SHORT;
          short_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.coin_ack) begin
          rem_d = rem_q - coin_val;
          case (coin_q)
            COIN_DOL: nd_d = nd_q - ONE;
            COIN_FIF: nf_d = nf_q - ONE;
            COIN_QTR: nq_d = nq_q - ONE;
            default:  ;
          endcase
          coin_d  = COIN_NONE;
          cvld_d  = 1'b0;
          state_d = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      nq_q    <= '0;
      nf_q    <= '0;
      nd_q    <= '0;
      coin_q  <= COIN_NONE;
      cvld_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      nq_q    <= nq_d;
      nf_q    <= nf_d;
      nd_q    <= nd_d;
      coin_q  <= coin_d;
      cvld_q  <= cvld_d;
      done_q  <= done_d;
      short_q <= short_d;
    end
  end

  assign bus.refund_ready = (state_q == S_IDLE);
  assign bus.coin_out     = coin_q;
  assign bus.coin_valid   = cvld_q;
  assign busy             = (state_q != S_IDLE);
  assign remaining        = rem_q;
  assign done             = done_q;
  assign short            = short_q;
  assign cnt_q            = nq_q;
  assign cnt_f            = nf_q;
  assign cnt_d            = nd_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model queues the expected
// coins per request, the hopper side pops and compares each coin as it appears.
module tb_change_dispenser;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [CW-1:0] load_q, load_f, load_d;
  logic [CW-1:0] cnt_q, cnt_f, cnt_d;
  logic          busy, done, short;
  logic [2:0]    remaining;

  change_dispenser_if bus();

  change_dispenser #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .load_en   (load_en),
    .load_q    (load_q),
    .load_f    (load_f),
    .load_d    (load_d),
    .cnt_q     (cnt_q),
    .cnt_f     (cnt_f),
    .cnt_d     (cnt_d),
    .busy      (busy),
    .remaining (remaining),
    .done      (done),
    .short     (short)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  int         mq, mf, md, m_rem;
  bit         m_done;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Greedy reference: queue the coins a request should produce.
  task automatic model_req(input int amt);
    m_rem = amt;
    while (1) begin
      if (m_rem >= 4 && md > 0)      begin exp_q.push_back(5'b01000); m_rem -= 4; md--; end
      else if (m_rem >= 2 && mf > 0) begin exp_q.push_back(5'b00010); m_rem -= 2; mf--; end
      else if (m_rem >= 1 && mq > 0) begin exp_q.push_back(5'b00001); m_rem -= 1; mq--; end
      else break;
    end
    m_done = (m_rem == 0);
  endtask

  task automatic chk_inv(input string tag);
    chk({tag, "_cq"}, 32'(cnt_q), 32'(mq));
    chk({tag, "_cf"}, 32'(cnt_f), 32'(mf));
    chk({tag, "_cd"}, 32'(cnt_d), 32'(md));
  endtask

  task automatic do_load(input int q, input int f, input int d);
    @(negedge clk);
    load_en = 1'b1; load_q = CW'(q); load_f = CW'(f); load_d = CW'(d);
    @(negedge clk);
    load_en = 1'b0;
    mq = q; mf = f; md = d;
    chk_inv("load");
  endtask

  // Returns at the negedge just after the accepting edge (DUT in SELECT).
  task automatic send_req(input int amt);
    @(negedge clk);
    chk("req_ready", 32'(bus.refund_ready), 32'd1);
    bus.refund_valid = 1'b1;
    bus.refund_amt   = 3'(amt);
    model_req(amt);
    @(negedge clk);
    bus.refund_valid = 1'b0;
  endtask

  task automatic run_end(input int ack_lat);
    int         cyc = 0;
    bit         fin = 0;
    bit         got_done = 0, got_short = 0;
    logic [4:0] exp;
    while (!fin && cyc < 200) begin
      if (done || short) begin
        fin = 1; got_done = done; got_short = short;
      end else if (bus.coin_valid) begin
        if (exp_q.size() == 0) exp = 5'b00000;
        else exp = exp_q.pop_front();
        chk("coin", 32'(bus.coin_out), 32'(exp));
        for (int k = 0; k < ack_lat; k++) begin
          @(negedge clk); cyc++;
          chk("hold_vld", 32'(bus.coin_valid), 32'd1);
          chk("hold_coin", 32'(bus.coin_out), 32'(exp));
        end
        bus.coin_ack = 1'b1;
        @(negedge clk); cyc++;
        bus.coin_ack = 1'b0;
        chk("gap_vld", 32'(bus.coin_valid), 32'd0);
      end else begin
        @(negedge clk); cyc++;
      end
    end
    chk("finished", 32'(fin), 32'd1);
    chk("done", 32'(got_done), 32'(m_done));
    chk("short", 32'(got_short), 32'(!m_done));
    chk("remaining", 32'(remaining), 32'(m_rem));
    chk("left_coins", 32'(exp_q.size()), 32'd0);
    chk_inv("end");
    @(negedge clk);
    chk("pulse_end", 32'({done, short}), 32'd0);
    chk("ready_back", 32'(bus.refund_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    load_en = 1'b0; load_q = '0; load_f = '0; load_d = '0;
    bus.refund_valid = 1'b0; bus.refund_amt = '0; bus.coin_ack = 1'b0;
    mq = 0; mf = 0; md = 0;
    #3;
    chk("rst_ready", 32'(bus.refund_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(bus.coin_valid), 32'd0);
    chk("rst_coin", 32'(bus.coin_out), 32'd0);
    chk("rst_pulses", 32'({done, short}), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    chk_inv("rst");
    @(negedge clk);
    reset = 1'b1;

    // Full payout of $1.75: dollar, fifty, quarter.
    do_load(2, 1, 1);
    send_req(7);
    run_end(1);
    chk("t1_cq", 32'(cnt_q), 32'd1);
    chk("t1_cd", 32'(cnt_d), 32'd0);

    // Shortfall: only fifty + quarter against a dollar request.
    do_load(1, 1, 0);
    send_req(4);
    run_end(1);
    chk("t2_rem", 32'(remaining), 32'd1);

    // Zero amount: done two cycles after acceptance, no coin.
    send_req(0);
    chk("z_busy", 32'(busy), 32'd1);
    chk("z_done0", 32'(done), 32'd0);
    @(negedge clk);
    chk("z_done1", 32'(done), 32'd1);
    chk("z_vld", 32'(bus.coin_valid), 32'd0);
    chk("z_notready", 32'(bus.refund_ready), 32'd0);
    @(negedge clk);
    chk("z_ready", 32'(bus.refund_ready), 32'd1);
    chk("z_done2", 32'(done), 32'd0);

    // Stalled hopper, then a stray ack while idle.
    do_load(3, 0, 0);
    send_req(1);
    run_end(5);
    @(negedge clk);
    bus.coin_ack = 1'b1;
    @(negedge clk);
    bus.coin_ack = 1'b0;
    @(negedge clk);
    chk_inv("idle_ack");
    chk("idle_ack_busy", 32'(busy), 32'd0);

    // Load while busy is ignored; load in idle takes effect.
    do_load(2, 0, 0);
    send_req(1);
    load_en = 1'b1; load_q = 4'd9; load_f = '0; load_d = '0;
    @(negedge clk);
    load_en = 1'b0;
    chk("busy_load_cq", 32'(cnt_q), 32'd2);
    chk("busy_load_vld", 32'(bus.coin_valid), 32'd1);
    run_end(1);
    do_load(9, 0, 0);

    // Mixed loads and amounts checked against the greedy model.
    for (int i = 0; i < 8; i++) begin
      do_load($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      send_req($urandom_range(0, 7));
      run_end($urandom_range(0, 2));
    end

    // Asynchronous reset while a coin is on offer.
    do_load(1, 0, 0);
    send_req(1);
    @(negedge clk);
    chk("pre_rst_vld", 32'(bus.coin_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_vld", 32'(bus.coin_valid), 32'd0);
    chk("arst_coin", 32'(bus.coin_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    mq = 0; mf = 0; md = 0;
    chk_inv("arst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.refund_ready), 32'd1);
    chk("post_rst_vld", 32'(bus.coin_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out refund/change for the vending controller as a sequence of physical coins to the coin hopper. It uses the same 5-bit one-hot coin code as the coin-acceptance path. It accepts a refund amount in quarter units, selects coins greedily (largest first) from a loadable on-board inventory, and hands each coin to the hopper through a valid/ack handshake. When the inventory cannot cover the full amount, it reports a shortfall instead of completing.

## Interface
- COUNT_W, default 4: width of each coin inventory counter.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- refund_valid  in  1  a refund request is present.
- refund_amt  in  3  refund amount in quarters, 0..7 ($0.00..$1.75).
- refund_ready  out  1  dispenser can accept a request; high only in IDLE.
- coin_out  out  5  coin code to the hopper: 00001 quarter, 00010 fifty, 01000 dollar. 00000 when idle. 00100 and 10000 are never driven.
- coin_valid  out  1  coin_out holds a coin to eject.
- coin_ack  in  1  hopper has ejected the coin; sampled only while coin_valid=1.
- load_en  in  1  overwrite inventory; honoured only in IDLE.
- load_q, load_f, load_d  in  COUNT_W  new quarter, fifty and dollar counts.
- cnt_q, cnt_f, cnt_d  out  COUNT_W  current inventory.
- busy  out  1  high in any state other than IDLE.
- remaining  out  3  quarters still owed for the current or last request.
- done  out  1  one-cycle pulse: refund completed in full.
- short  out  1  one-cycle pulse: refund aborted for lack of coins.

## Operation
- States: IDLE, SELECT, ISSUE, DONE, SHORT.
- **IDLE:** refund_ready=1.
  - A request is accepted when refund_valid=1 in IDLE; remaining←refund_amt; next state SELECT.
  - load_en=1 in IDLE: cnt_*←load_*.
  - If load_en and refund_valid are both high in the same cycle, both take effect. Selection uses the loaded counts.
- **SELECT:**
  - remaining=0 → DONE.
  - Else if remaining≥4 and cnt_d>0 → coin_out←01000.
  - Else if remaining≥2 and cnt_f>0 → coin_out←00010.
  - Else if remaining≥1 and cnt_q>0 → coin_out←00001.
  - After any coin choice, next state is ISSUE.
  - Else → SHORT.
- **ISSUE:**
  - coin_valid=1; coin_out held stable.
  - On coin_ack=1: remaining decrements by the coin value (4, 2 or 1), the matching cnt_* decrements by 1, and coin_out←00000. Next state SELECT.
  - Without coin_ack, stay in ISSUE indefinitely.
- **DONE:** done=1 for one cycle → IDLE.
- **SHORT:** short=1 for one cycle → IDLE.
  - remaining keeps the unpaid amount until the next accepted request.
  - Coins already ejected are not recovered.
- coin_ack outside ISSUE is ignored. load_en outside IDLE is ignored.
- Inventory never underflows, because a coin is only selected when its count is >0.
- All decrement arithmetic is unsigned. remaining never underflows, because a coin is only selected when remaining ≥ its value.
- Reset values: state IDLE, refund_ready=1, busy=0, coin_valid=0, coin_out=00000, done=0, short=0, remaining=0, cnt_q=cnt_f=cnt_d=0.

## Timing
- Request accepted at edge N → SELECT in N+1 → coin_valid=1 in N+2.
- coin_ack high in cycle M (in ISSUE):
  - coin_valid=0 in M+1 (SELECT).
  - The next coin_valid is high in M+2.
  - Counts update at edge M+1.
- Minimum per-coin period: 2 cycles plus the hopper's ack latency.
- Zero-amount request: accept N → SELECT N+1 → done high in N+2 → refund_ready=1 in N+3.
- done/short are high in the cycle after the final SELECT. refund_ready returns one cycle later.
- coin_valid and coin_out are registered; no combinational path from coin_ack to coin_valid.
- Reset asserted at any time, including in ISSUE with coin_valid=1:
  - Outputs take their reset values immediately, without waiting for a clock edge.
  - Inventory is cleared.
  - An in-flight refund is abandoned.
- Deassertion is synchronised externally.

## Test plan
- Load q=2,f=1,d=1; refund_amt=7; ack each coin the cycle after it is valid. Required: coin_out sequence 01000, 00010, 00001; done pulse; then remaining=0, cnt_q=1, cnt_f=0, cnt_d=0.
- Load q=1,f=1,d=0; refund_amt=4. Required: coins 00010, 00001; then short pulse with remaining=1, cnt_q=0, cnt_f=0.
- refund_amt=0 accepted at cycle N. Required: coin_valid never high; done high at N+2; refund_ready high at N+3.
- Hold coin_ack low for 5 cycles in ISSUE. Required: coin_valid and coin_out stable throughout. A coin_ack pulse while IDLE changes no counter.
- Drive load_en=1 with load_q=9 while busy. Required: cnt_q unchanged. Repeat in IDLE: cnt_q=9 the next cycle.
- Assert reset mid-ISSUE, between clock edges. Required: coin_valid=0, coin_out=00000, busy=0, cnt_*=0 before the next edge; refund_ready=1 after release.
